// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control unit for the MIPS-subset datapath.
// Moore FSM that sequences each instruction through fetch/decode/execute/memory/writeback
// and decodes all datapath controls from the current state (plus the wait counter in
// FETCH and MEM_READ).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   opcode      in   IR[31:26]
//   funct       in   IR[5:0]
//   zero        in   ALU zero flag (qualification happens in the datapath via PCWriteCond)
//   PCWrite     out  unconditional PC load
//   PCWriteCond out  PC load qualified by zero
//   IorD        out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite    out  memory write strobe
//   IRWrite     out  IR load
//   RegDst      out  write register select (0 = rt, 1 = rd)
//   MemtoReg    out  writeback select (0 = ALUOut, 1 = MDR)
//   RegWrite    out  register-file write
//   ALUSrcA     out  ALU input A (0 = PC, 1 = register A)
//   ALUSrcB     out  ALU input B (00 imm, 01 const 4, 10 reg B, 11 imm << 2)
//   ALUOp       out  ALU operation (001 add, 010 sub, 011 and, 110 xor)
//   PCSource    out  PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   illegal     out  unsupported opcode/funct trapped
module mc_control_fsm #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal
);

   typedef enum logic [3:0] {
      StRst,
      StFetch,
      StDecode,
      StRExec,
      StRWb,
      StMemAddr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StAddiExec,
      StAddiWb,
      StBranch,
      StJump,
      StIllegal
   } state_t;

   localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_next;
   logic       w_cnt_last;
   logic       w_funct_ok;
   logic [2:0] w_funct_op;
   logic       w_unused_zero;

   // Branch resolution happens in the datapath; the FSM never looks at zero.
   assign w_unused_zero = zero;
   assign w_cnt_last    = (r_cnt == WaitLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StRst;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Supported R-type functions and their ALU operation.
   always_comb begin
      w_funct_ok = 1'b1;
      w_funct_op = 3'b000;
      unique case (funct)
         6'h20:   w_funct_op = 3'b001;
         6'h22:   w_funct_op = 3'b010;
         6'h24:   w_funct_op = 3'b011;
         6'h26:   w_funct_op = 3'b110;
         default: w_funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      IorD         = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 3'b000;
      PCSource     = 2'b00;
      illegal      = 1'b0;

      case (r_state)
         StRst: begin
            w_cnt_next   = 3'd0;
            w_state_next = StFetch;
         end
         StFetch: begin
            // Wait cycles drive nothing; IR/PC load only once memory data is valid.
            if (w_cnt_last) begin
               IRWrite      = 1'b1;
               PCWrite      = 1'b1;
               ALUSrcB      = 2'b01;
               ALUOp        = 3'b001;
               w_cnt_next   = 3'd0;
               w_state_next = StDecode;
            end else begin
               w_cnt_next = r_cnt + 3'd1;
            end
         end
         StDecode: begin
            // Branch target computed speculatively into ALUOut.
            ALUSrcB = 2'b11;
            ALUOp   = 3'b001;
            case (opcode)
               6'h00:        w_state_next = w_funct_ok ? StRExec : StIllegal;
               6'h23, 6'h2B: w_state_next = StMemAddr;
               6'h08:        w_state_next = StAddiExec;
               6'h04:        w_state_next = StBranch;
               6'h02:        w_state_next = StJump;
               default:      w_state_next = StIllegal;
            endcase
         end
         StRExec: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = 2'b10;
            ALUOp        = w_funct_op;
            w_state_next = StRWb;
         end
         StRWb: begin
            RegDst       = 1'b1;
            RegWrite     = 1'b1;
            w_state_next = StFetch;
         end
         StMemAddr: begin
            ALUSrcA      = 1'b1;
            ALUOp        = 3'b001;
            // IR is stable after FETCH, so opcode still selects lw vs sw here.
            w_state_next = (opcode == 6'h2B) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            IorD = 1'b1;
            if (w_cnt_last) begin
               w_cnt_next   = 3'd0;
               w_state_next = StMemWb;
            end else begin
               w_cnt_next = r_cnt + 3'd1;
            end
         end
         StMemWb: begin
            MemtoReg     = 1'b1;
            RegWrite     = 1'b1;
            w_state_next = StFetch;
         end
         StMemWrite: begin
            IorD         = 1'b1;
            MemWrite     = 1'b1;
            w_state_next = StFetch;
         end
         StAddiExec: begin
            ALUSrcA      = 1'b1;
            ALUOp        = 3'b001;
            w_state_next = StAddiWb;
         end
         StAddiWb: begin
            RegWrite     = 1'b1;
            w_state_next = StFetch;
         end
         StBranch: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = 2'b10;
            ALUOp        = 3'b010;
            PCWriteCond  = 1'b1;
            PCSource     = 2'b01;
            w_state_next = StFetch;
         end
         StJump: begin
            PCWrite      = 1'b1;
            PCSource     = 2'b10;
            w_state_next = StFetch;
         end
         StIllegal: begin
            // Trap is sticky; only reset leaves it.
            illegal = 1'b1;
         end
         default: begin
            w_cnt_next   = 3'd0;
            w_state_next = StRst;
         end
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized self-checking bench for mc_control_fsm.
// A behavioural model expands each instruction into its per-cycle expected control
// vectors; one compare process checks the DUT against that queue on every falling edge.
// Instruction latencies are also measured on the DUT and pinned to literal values.
module tb_mc_control_fsm;

   localparam int unsigned MW = 1;

   typedef struct packed {
      logic       pcw;
      logic       pcwc;
      logic       iord;
      logic       memw;
      logic       irw;
      logic       regdst;
      logic       memtoreg;
      logic       regw;
      logic       srca;
      logic [1:0] srcb;
      logic [2:0] aluop;
      logic [1:0] pcsrc;
      logic       ill;
   } outs_t;

   typedef struct {
      outs_t o;
      string tag;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic       ALUSrcA, illegal;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   outs_t      act;

   exp_t exp_q[$];
   int   irw_hist[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   mc_control_fsm #(.MEM_WAIT(MW)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .PCWrite    (PCWrite),
      .PCWriteCond(PCWriteCond),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .PCSource   (PCSource),
      .illegal    (illegal)
   );

   assign act = {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_now(input string tag, input outs_t want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%05h expected=%05h", tag, cyc, act, want);
      end
   endtask

   // Compare process: one expected vector per cycle, sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (IRWrite === 1'b1) irw_hist.push_back(cyc);
         n_cmp++;
         if ((PCWrite & PCWriteCond) !== 1'b0 || (MemWrite & RegWrite) !== 1'b0) begin
            n_fail++;
            $display("FAIL exclusive cyc=%0d got=%05h expected no PCWrite&PCWriteCond nor MemWrite&RegWrite",
                     cyc, act);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_now(e.tag, e.o);
         end
      end
   end

   task automatic push(input outs_t o, input string tag);
      exp_t e;
      e.o   = o;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   function automatic bit alu_of(input logic [5:0] fn, output logic [2:0] op);
      op = 3'b000;
      case (fn)
         6'h20:   op = 3'b001;
         6'h22:   op = 3'b010;
         6'h24:   op = 3'b011;
         6'h26:   op = 3'b110;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   // Behavioural model: the cycle-by-cycle control vectors one instruction must produce.
   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, output bit trapped);
      outs_t      v;
      outs_t      addr;
      logic [2:0] a;
      bit         ok;
      for (int i = 0; i < int'(MW); i++) push('0, "fetch_wait");
      v = '0; v.irw = 1; v.pcw = 1; v.srcb = 2'b01; v.aluop = 3'b001;
      push(v, "fetch");
      v = '0; v.srcb = 2'b11; v.aluop = 3'b001;
      push(v, "decode");
      addr = '0; addr.srca = 1; addr.srcb = 2'b00; addr.aluop = 3'b001;
      trapped = 1'b0;
      case (op)
         6'h00: begin
            ok = alu_of(fn, a);
            if (ok) begin
               v = '0; v.srca = 1; v.srcb = 2'b10; v.aluop = a;
               push(v, "r_exec");
               v = '0; v.regdst = 1; v.regw = 1;
               push(v, "r_wb");
            end else begin
               trapped = 1'b1;
            end
         end
         6'h23: begin
            push(addr, "lw_addr");
            v = '0; v.iord = 1;
            for (int i = 0; i <= int'(MW); i++) push(v, "mem_read");
            v = '0; v.memtoreg = 1; v.regw = 1;
            push(v, "mem_wb");
         end
         6'h2B: begin
            push(addr, "sw_addr");
            v = '0; v.iord = 1; v.memw = 1;
            push(v, "mem_write");
         end
         6'h08: begin
            push(addr, "addi_exec");
            v = '0; v.regw = 1;
            push(v, "addi_wb");
         end
         6'h04: begin
            v = '0; v.srca = 1; v.srcb = 2'b10; v.aluop = 3'b010; v.pcwc = 1; v.pcsrc = 2'b01;
            push(v, "branch");
         end
         6'h02: begin
            v = '0; v.pcw = 1; v.pcsrc = 2'b10;
            push(v, "jump");
         end
         default: trapped = 1'b1;
      endcase
      if (trapped) begin
         v = '0; v.ill = 1;
         for (int i = 0; i < 12; i++) push(v, "illegal");
      end
   endtask

   task automatic drain();
      while (exp_q.size() != 0) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zv,
                            output bit trapped);
      drain();
      opcode = op;
      funct  = fn;
      zero   = zv;
      push_instr(op, fn, trapped);
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge.
   task automatic do_reset(input int n, input bit imm, input string tag);
      reset = 1'b1;
      #1;
      if (imm) check_now(tag, '0);
      for (int i = 0; i < n; i++) push('0, "reset_hold");
      drain();
      reset = 1'b0;
   endtask

   // Measured on the DUT: cycles between the IR loads of this instruction and the next.
   task automatic lat_check(input logic [5:0] op, input logic [5:0] fn, input logic zv,
                            input int lat, input string tag);
      int n0;
      int gap;
      bit t;
      drain();
      n0 = irw_hist.size();
      run_instr(op, fn, zv, t);
      run_instr(6'h02, 6'h00, 1'b0, t);
      drain();
      n_cmp++;
      if (irw_hist.size() < n0 + 2) begin
         n_fail++;
         $display("FAIL %s: IR loads seen=%0d required=2", tag, irw_hist.size() - n0);
      end else begin
         gap = irw_hist[n0+1] - irw_hist[n0];
         if (gap != lat) begin
            n_fail++;
            $display("FAIL %s: latency got=%0d required=%0d", tag, gap, lat);
         end
      end
   endtask

   initial begin
      bit         t;
      int         r;
      int         k;
      logic [5:0] op;
      logic [5:0] fn;
      logic [5:0] legal_fn[4];
      legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24; legal_fn[3] = 6'h26;
      reset  = 1'b1;
      opcode = 6'h00;
      funct  = 6'h20;
      zero   = 1'b0;

      do_reset(3, 1'b0, "reset_init");

      // Latencies with MEM_WAIT=1 (M=2): R/addi/sw 5, lw 7, beq/j 4.
      lat_check(6'h00, 6'h22, 1'b0, 5, "lat_sub");
      lat_check(6'h23, 6'h00, 1'b0, 7, "lat_lw");
      lat_check(6'h2B, 6'h00, 1'b0, 5, "lat_sw");
      lat_check(6'h08, 6'h00, 1'b0, 5, "lat_addi");
      lat_check(6'h04, 6'h00, 1'b1, 4, "lat_beq");
      lat_check(6'h02, 6'h00, 1'b0, 4, "lat_j");

      // Unsupported opcode traps until reset.
      run_instr(6'h3F, 6'h00, 1'b0, t);
      drain();
      do_reset(2, 1'b1, "reset_from_illegal");

      // Reset during the first MEM_READ wait cycle, then a normal fetch.
      run_instr(6'h23, 6'h00, 1'b0, t);
      while (exp_q.size() > int'(MW) + 1) begin
         @(negedge clk);
         #1;
      end
      exp_q.delete();
      do_reset(2, 1'b1, "reset_mid_read");
      run_instr(6'h00, 6'h26, 1'b0, t);

      for (int n = 0; n < 80; n++) begin
         r  = $urandom_range(0, 9);
         fn = legal_fn[$urandom_range(0, 3)];
         case (r)
            0, 1, 2: op = 6'h00;
            3:       op = 6'h23;
            4:       op = 6'h2B;
            5:       op = 6'h08;
            6:       op = 6'h04;
            7:       op = 6'h02;
            8:       op = 6'($urandom_range(0, 63));
            default: begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
         endcase
         run_instr(op, fn, 1'($urandom_range(0, 1)), t);
         if (t) begin
            drain();
            do_reset(1 + $urandom_range(0, 2), 1'b1, "reset_from_illegal");
         end else if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, exp_q.size() - 1);
            while (exp_q.size() > k) begin
               @(negedge clk);
               #1;
            end
            exp_q.delete();
            do_reset(1 + $urandom_range(0, 2), 1'b1, "reset_mid_instr");
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main control unit for the MIPS-subset datapath.
- Drives the ALU source-A/B select lines (ALUSrcB encoding: 00 sign-extended imm, 01 constant 4, 10 register B, 11 imm shifted left 2), the ALU operation, and the memory, register-file, IR and PC write enables.
- Moore FSM: it decodes opcode/funct from the IR and sequences every instruction through fetch/decode/execute/memory/writeback.

Parameters:
- MEM_WAIT, 1, extra wait cycles a memory read needs before data is valid (legal range 0..7).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by zero
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register-file write
- ALUSrcA  output  1  ALU input A: 0 = PC, 1 = register A
- ALUSrcB  output  2  encoding as in Overview
- ALUOp  output  3  ALU operation: 001 add, 010 sub, 011 and, 110 xor
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  output  1  unsupported opcode/funct trapped

Behaviour:
- Output model:
  - State register plus 3-bit wait counter, both cleared asynchronously by reset.
  - All outputs decode combinationally from state (plus counter in FETCH/MEM_READ) and are 0 in any unlisted case.
- Reset:
  - Forces state RST immediately, including mid-instruction.
  - RST: all outputs 0. Next state FETCH.
- FETCH:
  - IorD=0.
  - Counter increments each cycle until it reaches MEM_WAIT.
  - On that final cycle only: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=001, PCSource=00. Counter clears; next state DECODE.
  - MEM_WAIT=0 gives a single-cycle FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=001 (branch target into ALUOut). Dispatch on opcode:
  - 0x00: to R_EXEC if funct ∈ {0x20, 0x22, 0x24, 0x26}, else ILLEGAL.
  - 0x23 lw / 0x2B sw: to MEM_ADDR.
  - 0x08 addi: to ADDI_EXEC.
  - 0x04 beq: to BRANCH.
  - 0x02 j: to JUMP.
  - Any other opcode: to ILLEGAL.
- R_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp from funct (0x20→001, 0x22→010, 0x24→011, 0x26→110). Next R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=00, ALUOp=001. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: IorD=1. Counter waits MEM_WAIT cycles as in FETCH, then next MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 for exactly 1 cycle. Next FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=001. Next ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=10, ALUOp=010, PCWriteCond=1, PCSource=01. Next FETCH regardless of zero.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ILLEGAL: illegal=1, all write enables 0. Stays in ILLEGAL until reset.
- Latencies in cycles, with M = MEM_WAIT+1:
  - R-type, addi: M+3.
  - lw: 2M+3.
  - sw: M+3.
  - beq, j: M+2.
- Exclusivity:
  - PCWrite and PCWriteCond are never both 1.
  - MemWrite and RegWrite are never both 1.
  - No write enable is asserted during a wait cycle.

Test Plan:
- Reset held 3 cycles, released with MEM_WAIT=1 → all outputs 0 during reset. FETCH lasts 2 cycles, with IRWrite=PCWrite=1 only in the 2nd. Then DECODE shows ALUSrcB=11.
- opcode=0x00, funct=0x22 → R_EXEC drives ALUSrcA=1, ALUSrcB=10, ALUOp=010. R_WB drives RegDst=1, RegWrite=1. Total 5 cycles.
- opcode=0x23 (lw), MEM_WAIT=1 → MEM_ADDR drives ALUSrcB=00. IorD=1 for 2 cycles. MEM_WB drives MemtoReg=1, RegWrite=1. Total 7 cycles.
- opcode=0x2B (sw) → MemWrite high for exactly 1 cycle, RegWrite never high. opcode=0x04 with zero=1 → BRANCH drives PCWriteCond=1, PCSource=01, ALUOp=010.
- opcode=0x3F → illegal=1 from the cycle after DECODE, persisting 10+ cycles with all write enables 0. Reset asserted → illegal drops to 0 immediately (asynchronously).
- Reset asserted in MEM_READ wait cycle → state RST and all outputs 0 immediately. The next instruction fetches normally with the counter restarted at 0.
